// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant is issued from IDLE one edge after the request is sampled. It is kept
// until the owner drops its request or has held the grant for MAX_HOLD cycles.
// On a forced release, timeout pulses for one cycle.
module round_robin_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_id,
    output logic       grant_valid,
    output logic       timeout
);

    localparam logic [7:0] HOLD_LIMIT = MAX_HOLD[7:0];

    typedef enum logic {
        ST_IDLE,
        ST_OWNED
    } state_t;

    state_t     r_state;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;
    logic [3:0] r_grant;
    logic [1:0] r_grant_id;
    logic       r_grant_valid;
    logic       r_timeout;

    logic [1:0] w_sel;
    logic       w_found;
    logic       w_owner_req;
    logic [1:0] w_next_ptr;
    logic       w_hold_expired;

    // Pick the first asserted request, starting at the priority pointer and wrapping
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = r_ptr + 2'(k);
            if (!w_found && req[idx]) begin
                w_sel   = idx;
                w_found = 1'b1;
            end
        end
    end

    // Owner status and the pointer value used on any exit from OWNED
    always_comb begin
        w_owner_req    = req[r_grant_id];
        w_next_ptr     = r_grant_id + 2'd1;
        w_hold_expired = (r_cnt == HOLD_LIMIT);
    end

    // Arbitration FSM with registered grant, id, valid and timeout outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_found) begin
                        r_state       <= ST_OWNED;
                        r_cnt         <= 8'd1;
                        r_grant_id    <= w_sel;
                        r_grant       <= 4'b0001 << w_sel;
                        r_grant_valid <= 1'b1;
                    end
                end
                ST_OWNED: begin
                    // A voluntary release wins over the hold limit, so no timeout then
                    if (!w_owner_req) begin
                        r_state       <= ST_IDLE;
                        r_ptr         <= w_next_ptr;
                        r_cnt         <= '0;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                    end else if (w_hold_expired) begin
                        r_state       <= ST_IDLE;
                        r_ptr         <= w_next_ptr;
                        r_cnt         <= '0;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_timeout     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural owner/priority model.
module tb_round_robin_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // Reference model: current owner (-1 = none), priority start, hold length, timeout pulse
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    round_robin_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] exp_grant();
        if (m_owner < 0) return 4'b0000;
        return 4'(1 << m_owner);
    endfunction

    function automatic logic exp_valid();
        return (m_owner >= 0);
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    // Advance the model by one rising edge using the inputs sampled there
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (enable && req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                            m_owner = (m_ptr + k) % 4;
                            m_hold  = 1;
                        end
                    end
                end
            end else if (!req[m_owner]) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else if (m_hold == MAXH) begin
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'b0000;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        req    = 4'b1111;
        cycle();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'b00 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: grant=%b valid=%b id=%0d to=%b expected 0000/0/0/0",
                     grant, grant_valid, grant_id, timeout);
        end
        reset = 1'b0;
        req   = 4'b0000;
        cycle();
    endtask

    task automatic test_basic_release();
        do_reset();
        enable = 1'b1;
        req    = 4'b1010;
        cycle();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_grant: grant=%b id=%0d expected 0010 id=1", grant, grant_id);
        end
        req = 4'b1000;
        cycle();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: grant=%b valid=%b expected 0000/0", grant, grant_valid);
        end
        cycle();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL basic_next_grant: grant=%b id=%0d expected 1000 id=3", grant, grant_id);
        end
    endtask

    task automatic test_rotation();
        int seen[$];
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic prev_valid;
        do_reset();
        prev_valid = 1'b0;
        enable = 1'b1;
        req    = 4'b1111;
        for (int c = 0; c < 40 && seen.size() < 5; c++) begin
            cycle();
            checks++;
            if (grant !== exp_grant() || grant_valid !== exp_valid()) begin
                errors++;
                $display("FAIL rotation_cycle %0d: grant=%b valid=%b expected %b/%b",
                         c, grant, grant_valid, exp_grant(), exp_valid());
            end
            if (grant_valid && !prev_valid) seen.push_back(int'(grant_id));
            prev_valid = grant_valid;
            if (m_owner >= 0 && m_hold == 2) req = 4'b1111 & ~(4'(1 << m_owner));
            else req = 4'b1111;
        end
        checks++;
        if (seen.size() != 5) begin
            errors++;
            $display("FAIL rotation_count: grants seen=%0d expected 5 within cycle budget", seen.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (seen[i] != exp_seq[i]) begin
                    errors++;
                    $display("FAIL rotation_order[%0d]: id=%0d expected %0d", i, seen[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        enable = 1'b1;
        req    = 4'b0001;
        for (int i = 0; i < MAXH; i++) begin
            cycle();
            checks++;
            if (grant !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: grant=%b to=%b expected 0001/0", i, grant, timeout);
            end
        end
        cycle();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse: grant=%b to=%b expected 0000/1", grant, timeout);
        end
        cycle();
        checks++;
        if (grant !== 4'b0001 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: grant=%b to=%b expected 0001/0", grant, timeout);
        end
        req = 4'b0000;
        cycle();
        cycle();
    endtask

    task automatic test_enable_hold();
        do_reset();
        enable = 1'b1;
        req    = 4'b0100;
        cycle();
        enable = 1'b0;
        req    = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (grant !== 4'b0100 || grant_id !== 2'd2) begin
                errors++;
                $display("FAIL enable_keep[%0d]: grant=%b id=%0d expected 0100 id=2", i, grant, grant_id);
            end
        end
        req = 4'b1011;
        cycle();
        cycle();
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL enable_blocked: grant=%b valid=%b expected 0000/0", grant, grant_valid);
        end
        enable = 1'b1;
        cycle();
        checks++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            errors++;
            $display("FAIL enable_resume: grant=%b id=%0d expected 1000 id=3", grant, grant_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable = 1'b1;
        req    = 4'b0001;
        cycle();
        cycle();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL areset_pre: grant=%b expected 0001", grant);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: grant=%b valid=%b to=%b expected 0000/0/0",
                     grant, grant_valid, timeout);
        end
        model_reset();
        cycle();
        reset = 1'b0;
        req   = 4'b0110;
        cycle();
        checks++;
        if (grant !== 4'b0010 || grant_id !== 2'd1) begin
            errors++;
            $display("FAIL areset_after: grant=%b id=%0d expected 0010 id=1", grant, grant_id);
        end
    endtask

    task automatic test_coincide();
        do_reset();
        enable = 1'b1;
        req    = 4'b0001;
        for (int i = 0; i < MAXH; i++) cycle();
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL coincide_hold: grant=%b expected 0001", grant);
        end
        req = 4'b0000;
        cycle();
        checks++;
        if (grant !== 4'b0000 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL coincide_release: grant=%b to=%b expected 0000/0", grant, timeout);
        end
        req = 4'b0011;
        cycle();
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL coincide_ptr: grant=%b expected 0010", grant);
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 4) != 0);
            reset  = ($urandom_range(0, 59) == 0);
            cycle();
            checks++;
            if (grant !== exp_grant() || grant_valid !== exp_valid() || timeout !== m_to ||
                (exp_valid() && grant_id !== 2'(m_owner))) begin
                errors++;
                $display("FAIL random_cycle %0d: grant=%b valid=%b id=%0d to=%b expected grant=%b valid=%b to=%b",
                         c, grant, grant_valid, grant_id, timeout, exp_grant(), exp_valid(), m_to);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        req    = 4'b0000;
        test_reset();
        test_basic_release();
        test_rotation();
        test_timeout();
        test_enable_hold();
        test_async_reset();
        test_coincide();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
